// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and byte-mask helper shared by the MEM-stage load/store unit
package lsu_pkg;
  localparam logic [3:0] LS_SIZE_B = 4'b0001;
  localparam logic [3:0] LS_SIZE_H = 4'b0010;
  localparam logic [3:0] LS_SIZE_W = 4'b0100;
  localparam logic [3:0] LS_SIZE_D = 4'b1000;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE, ST_DRAIN} mau_state_e;
  // Any encoding that is not a recognised one-hot size is treated as a dword
  function automatic logic [7:0] size_to_mask(input logic [3:0] size);
    return (size == LS_SIZE_B) ? 8'h01 : (size == LS_SIZE_H) ? 8'h03 : (size == LS_SIZE_W) ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts a dcache dword down to the accessed bytes and sign/zero extends to full width
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [2:0]        i_off,
  input  logic [3:0]        i_size,
  input  logic              i_is_unsigned,
  output logic [DATA_W-1:0] o_result
);
  logic [DATA_W-1:0] w_shifted;
  assign w_shifted = i_rdata >> {i_off, 3'b000};
  assign o_result = (i_size == LS_SIZE_B) ? {{(DATA_W-8){~i_is_unsigned & w_shifted[7]}}, w_shifted[7:0]}
                  : (i_size == LS_SIZE_H) ? {{(DATA_W-16){~i_is_unsigned & w_shifted[15]}}, w_shifted[15:0]}
                  : (i_size == LS_SIZE_W) ? {{(DATA_W-32){~i_is_unsigned & w_shifted[31]}}, w_shifted[31:0]}
                  : w_shifted;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving the dcache handshake and the pipeline stall
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_instr_valid,
  input  logic                in_is_load,
  input  logic                in_is_store,
  input  logic                in_is_unsigned,
  input  logic [3:0]          in_ls_size,
  input  logic [ADDR_W-1:0]   in_ls_address,
  input  logic [DATA_W-1:0]   in_store_data,
  input  logic                redirect_flush,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   opload_read_data_wb,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_is_store,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W-1:0]   req_wdata,
  output logic [DATA_W/8-1:0] req_wmask,
  input  logic                resp_valid,
  input  logic [DATA_W-1:0]   resp_rdata
);
  mau_state_e        r_state;
  mau_state_e        w_next;
  logic [DATA_W-1:0] r_load;
  logic [DATA_W-1:0] w_load;
  logic [2:0]        w_off;
  logic              w_mem_op;
  logic              w_hs;
  logic              w_flush_ok;
  assign w_off      = in_ls_address[2:0];
  assign w_mem_op   = in_instr_valid & (in_is_load | in_is_store);
  assign w_hs       = req_valid & req_ready;
  // A flush may only take effect while nothing irrevocable is in flight on the dcache side
  assign w_flush_ok = redirect_flush & ((r_state == ST_IDLE) | ((r_state == ST_REQ) & ~w_hs) | (r_state == ST_WAIT));
  // In DRAIN the old op has already left EX/MEM, so any op seen there is new and must wait
  assign mem_stall  = reset_n & ~w_flush_ok & w_mem_op & (r_state != ST_DONE);
  assign req_valid  = r_state == ST_REQ;
  assign req_is_store        = in_is_store;
  assign req_addr            = {in_ls_address[ADDR_W-1:3], 3'b000};
  assign req_wdata           = in_store_data << {w_off, 3'b000};
  assign req_wmask           = size_to_mask(in_ls_size) << w_off;
  assign opload_read_data_wb = r_load;
  lsu_load_align #(.DATA_W(DATA_W)) u_align (
    .i_rdata       (resp_rdata),
    .i_off         (w_off),
    .i_size        (in_ls_size),
    .i_is_unsigned (in_is_unsigned),
    .o_result      (w_load)
  );
  // State register; reset drops any transaction in flight
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  // Load result register, updated only when a load response is taken in WAIT
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)                           r_load <= '0;
    else if (r_state == ST_WAIT && resp_valid) r_load <= w_load;
  // Next-state logic; accepted stores are never withdrawn, flushed loads still absorb their response
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = (w_mem_op & ~redirect_flush) ? ST_REQ : ST_IDLE;
      ST_REQ:   w_next = w_hs ? (in_is_store ? ST_DONE : ST_WAIT) : redirect_flush ? ST_IDLE : ST_REQ;
      ST_WAIT:  w_next = resp_valid ? ST_DONE : redirect_flush ? ST_DRAIN : ST_WAIT;
      ST_DONE:  w_next = ST_IDLE;
      ST_DRAIN: w_next = resp_valid ? ST_IDLE : ST_DRAIN;
      default:  w_next = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench for mem_access_unit with a dcache model
module tb_mem_access_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_instr_valid = 1'b0, in_is_load = 1'b0, in_is_store = 1'b0, in_is_unsigned = 1'b0;
  logic [3:0]  in_ls_size = 4'b0;
  logic [63:0] in_ls_address = '0, in_store_data = '0;
  logic        redirect_flush = 1'b0;
  logic        mem_stall;
  logic [63:0] opload_read_data_wb;
  logic        req_valid, req_ready = 1'b0, req_is_store;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid = 1'b0;
  logic [63:0] resp_rdata = '0;

  mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset_n(reset_n), .in_instr_valid(in_instr_valid), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_is_unsigned(in_is_unsigned), .in_ls_size(in_ls_size),
    .in_ls_address(in_ls_address), .in_store_data(in_store_data), .redirect_flush(redirect_flush),
    .mem_stall(mem_stall), .opload_read_data_wb(opload_read_data_wb), .req_valid(req_valid),
    .req_ready(req_ready), .req_is_store(req_is_store), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(resp_valid), .resp_rdata(resp_rdata)
  );

  always #5 clock = ~clock;

  typedef struct { logic st; logic [63:0] addr; logic [63:0] wdata; logic [7:0] mask; } req_t;
  typedef struct { logic ld; logic [63:0] val; } done_t;
  req_t        exp_req[$];
  done_t       exp_done[$];
  logic [63:0] pend_data[$];
  int          pend_dly[$];
  logic [63:0] mem [16];
  logic [63:0] last_ld = '0;
  int n_tests = 0, n_fail = 0;
  int ready_low = 0, fixed_lat = 1;
  bit ready_rand = 1'b0;

  function automatic int size_bytes(logic [3:0] sz);
    return (sz == 4'b0001) ? 1 : (sz == 4'b0010) ? 2 : (sz == 4'b0100) ? 4 : 8;
  endfunction

  function automatic logic [63:0] ref_load(logic [63:0] dw, int off, int nb, bit uns);
    logic [63:0] v, keep;
    v = dw >> (8 * off);
    if (nb == 8) return v;
    keep = (64'd1 << (8 * nb)) - 64'd1;
    v = v & keep;
    if (!uns && v[8*nb-1]) v = v | ~keep;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_op(bit ld, logic [3:0] sz, bit uns, logic [63:0] a, logic [63:0] sd, bit want_done);
    req_t r;
    done_t d;
    int nb, off;
    in_instr_valid = 1'b1; in_is_load = ld; in_is_store = !ld; in_is_unsigned = uns;
    in_ls_size = sz; in_ls_address = a; in_store_data = sd;
    nb = size_bytes(sz);
    off = int'(a[2:0]);
    r.st = !ld;
    r.addr = a & ~64'h7;
    r.wdata = sd << (8 * off);
    r.mask = 8'(((1 << nb) - 1) << off);
    exp_req.push_back(r);
    if (want_done) begin
      d.ld = ld;
      d.val = ld ? ref_load(mem[a[6:3]], off, nb, uns) : 64'd0;
      exp_done.push_back(d);
    end
  endtask

  task automatic wait_done(output int stalls);
    bit done = 1'b0;
    stalls = 0;
    while (!done) begin
      @(negedge clock);
      if (!mem_stall) done = 1'b1;
      else begin
        stalls++;
        if (stalls > 300) begin
          n_tests++; n_fail++;
          $display("FAIL op_timeout: still stalled after %0d cycles, required completion", stalls);
          done = 1'b1;
        end
      end
    end
    @(posedge clock); #1;
    in_instr_valid = 1'b0;
  endtask

  task automatic wait_hs();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(req_valid && req_ready) && n < 50);
    if (!(req_valid && req_ready)) begin
      n_tests++; n_fail++;
      $display("FAIL hs_timeout: no request handshake within %0d cycles", n);
    end
    @(posedge clock); #1;
  endtask

  // dcache model: drives ready and returns load responses in order
  initial forever begin
    @(posedge clock); #2;
    if (!reset_n) begin
      pend_data.delete(); pend_dly.delete();
      resp_valid = 1'b0; req_ready = 1'b0;
    end else begin
      resp_valid = 1'b0;
      if (pend_dly.size() > 0) begin
        if (pend_dly[0] == 0) begin
          resp_valid = 1'b1;
          resp_rdata = pend_data.pop_front();
          void'(pend_dly.pop_front());
        end else pend_dly[0] = pend_dly[0] - 1;
      end
      if (ready_low > 0) begin
        req_ready = 1'b0;
        ready_low--;
      end else req_ready = ready_rand ? ($urandom_range(9) < 7) : 1'b1;
    end
  end

  // request monitor: every cycle a request is presented it must match the oldest issued op
  always @(negedge clock) begin
    if (reset_n && req_valid) begin
      if (exp_req.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_req: got request to %h, expected none", req_addr);
      end else begin
        check("req_is_store", 64'(req_is_store), 64'(exp_req[0].st));
        check("req_addr", req_addr, exp_req[0].addr);
        if (exp_req[0].st) begin
          check("req_wdata", req_wdata, exp_req[0].wdata);
          check("req_wmask", 64'(req_wmask), 64'(exp_req[0].mask));
        end
        if (!redirect_flush) check("stall_in_req", 64'(mem_stall), 64'd1);
        if (req_ready) begin
          if (!exp_req[0].st) begin
            pend_data.push_back(mem[req_addr[6:3]]);
            pend_dly.push_back(fixed_lat > 0 ? fixed_lat - 1 : int'($urandom_range(3)));
          end
          void'(exp_req.pop_front());
        end
      end
    end
  end

  // completion monitor: a released (unstalled, unflushed) op must match the oldest expected result
  always @(negedge clock) begin : mon_done
    done_t d;
    if (reset_n && in_instr_valid && (in_is_load || in_is_store) && !mem_stall && !redirect_flush) begin
      if (exp_done.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL extra_done: got completion at %h, expected none", in_ls_address);
      end else begin
        d = exp_done.pop_front();
        if (d.ld) begin
          check("load_data", opload_read_data_wb, d.val);
          last_ld = d.val;
        end else check("opload_hold", opload_read_data_wb, last_ld);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int r;
    logic [3:0] sz;
    logic [3:0] odd_sz [4];
    odd_sz[0] = 4'b0000; odd_sz[1] = 4'b0011; odd_sz[2] = 4'b1111; odd_sz[3] = 4'b0110;
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    repeat (2) @(posedge clock);
    #1;
    in_instr_valid = 1'b1; in_is_load = 1'b1;
    @(negedge clock);
    check("stall_in_reset", 64'(mem_stall), 64'd0);
    check("req_valid_in_reset", 64'(req_valid), 64'd0);
    check("opload_in_reset", opload_read_data_wb, 64'd0);
    in_instr_valid = 1'b0; in_is_load = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_stall", 64'(mem_stall), 64'd0);
    check("idle_req_valid", 64'(req_valid), 64'd0);
    @(posedge clock); #1;

    mem[0] = 64'h0000_0000_8000_0000;
    fixed_lat = 2;
    drive_op(1'b1, 4'b0001, 1'b0, 64'h1003, 64'd0, 1'b1);
    wait_done(st);
    check("lb_stall_cycles", 64'(st), 64'd4);
    check("lb_value", opload_read_data_wb, 64'hFFFF_FFFF_FFFF_FF80);

    drive_op(1'b0, 4'b0010, 1'b0, 64'h1006, 64'h1234, 1'b1);
    wait_done(st);
    check("sh_stall_cycles", 64'(st), 64'd2);

    ready_low = 6;
    drive_op(1'b0, 4'b1000, 1'b0, 64'h1AB8, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    wait_done(st);
    check("sd_ready_wait_cycles", 64'(st), 64'd7);

    mem[2] = 64'h1111_2222_3333_4444;
    mem[5] = 64'h5555_6666_7777_8888;
    fixed_lat = 4;
    drive_op(1'b1, 4'b1000, 1'b0, 64'h1010, 64'd0, 1'b0);
    wait_hs();
    redirect_flush = 1'b1;
    @(negedge clock);
    check("flush_wait_stall", 64'(mem_stall), 64'd0);
    @(posedge clock); #1;
    redirect_flush = 1'b0;
    fixed_lat = 1;
    drive_op(1'b1, 4'b1000, 1'b0, 64'h1028, 64'd0, 1'b1);
    @(negedge clock);
    check("drain_stall", 64'(mem_stall), 64'd1);
    wait_done(st);
    check("drain_new_ld", opload_read_data_wb, 64'h5555_6666_7777_8888);

    ready_low = 100;
    drive_op(1'b0, 4'b0100, 1'b0, 64'h1104, 64'hCAFE_F00D, 1'b0);
    repeat (2) begin @(posedge clock); #1; end
    redirect_flush = 1'b1;
    @(negedge clock);
    check("flush_req_stall", 64'(mem_stall), 64'd0);
    @(posedge clock); #1;
    redirect_flush = 1'b0; in_instr_valid = 1'b0; ready_low = 0;
    void'(exp_req.pop_back());
    @(negedge clock);
    check("withdrawn_req_valid", 64'(req_valid), 64'd0);
    @(posedge clock); #1;

    mem[0] = 64'hDEAD_BEEF_0000_0000;
    mem[1] = 64'h0123_4567_89AB_CDEF;
    drive_op(1'b1, 4'b0100, 1'b1, 64'h2004, 64'd0, 1'b1);
    wait_done(st);
    check("lwu_value", opload_read_data_wb, 64'h0000_0000_DEAD_BEEF);
    drive_op(1'b1, 4'b1000, 1'b0, 64'h2008, 64'd0, 1'b1);
    wait_done(st);
    check("ld_value", opload_read_data_wb, 64'h0123_4567_89AB_CDEF);

    fixed_lat = 4;
    drive_op(1'b1, 4'b1000, 1'b0, 64'h1018, 64'd0, 1'b0);
    wait_hs();
    reset_n = 1'b0;
    last_ld = '0;
    @(negedge clock);
    check("reset_wait_stall", 64'(mem_stall), 64'd0);
    check("reset_wait_req_valid", 64'(req_valid), 64'd0);
    check("reset_wait_opload", opload_read_data_wb, 64'd0);
    @(posedge clock); #1;
    in_instr_valid = 1'b0; reset_n = 1'b1;
    @(negedge clock);
    check("post_reset_req_valid", 64'(req_valid), 64'd0);
    check("post_reset_stall", 64'(mem_stall), 64'd0);
    check("post_reset_opload", opload_read_data_wb, 64'd0);
    @(posedge clock); #1;

    ready_rand = 1'b1;
    fixed_lat = 0;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(2)) begin @(posedge clock); #1; end
      r = int'($urandom_range(4));
      sz = (r < 4) ? 4'(1 << r) : odd_sz[$urandom_range(3)];
      drive_op(1'($urandom_range(1)), sz, 1'($urandom_range(1)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      wait_done(st);
    end

    repeat (10) @(posedge clock);
    check("req_queue_empty", 64'(exp_req.size()), 64'd0);
    check("done_queue_empty", 64'(exp_done.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
